// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit:
// state codes, opcode/funct values and datapath select encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU control decode.
// Ports: aluop (00 add, 01 sub, 10 funct), funct -> aluctl.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] aluctl
);

  always_comb begin
    aluctl = ALU_ADD;
    case (aluop)
      ALUOP_SUB: aluctl = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct)
          FN_ADD:  aluctl = ALU_ADD;
          FN_SUB:  aluctl = ALU_SUB;
          FN_AND:  aluctl = ALU_AND;
          FN_OR:   aluctl = ALU_OR;
          FN_SLT:  aluctl = ALU_SLT;
          default: aluctl = ALU_ADD;
        endcase
      end
      default: aluctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing the shared datapath.
// Ports: clk, reset, op, funct, zero in; mux selects, enables, state out.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] aluctl,
  output logic [1:0] pcsrc,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic       pcwrite;
  logic       branch;
  logic       legal;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       memwrite_s;
  logic [1:0] aluop;
  logic [2:0] aluctl_dec;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    regwrite_s = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PC_ALURES;
    aluop      = ALUOP_ADD;
    legal      = 1'b1;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
        alusrcb   = SRCB_FOUR;
      end
      S_DECODE: alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMREAD: iord = 1'b1;
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
      end
      S_MEMWRITE: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        regwrite_s = 1'b1;
        regdst     = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop  (aluop),
    .funct  (funct),
    .aluctl (aluctl_dec)
  );

  // Illegal codes drive every output to 0, including aluctl.
  assign aluctl = legal ? aluctl_dec : 3'b000;

  // Architectural writes are suppressed in the reset cycle itself.
  assign irwrite  = irwrite_s  & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign pcen     = (pcwrite | (branch & zero)) & ~reset;
  assign state    = state_q;

endmodule
